// File: rtl/fetch_unit_if.sv
// fetch_unit_if: icache request/response bus and decode-side stream.
// master = fetch unit, slave = cache and decode environment.
interface fetch_unit_if;

  logic        icache_access;
  logic [31:0] icache_address;
  logic        icache_data_ready;
  logic [31:0] icache_data_out;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;

  modport master (
    output icache_access,
    output icache_address,
    input  icache_data_ready,
    input  icache_data_out,
    output out_valid,
    input  out_ready,
    output out_instruction,
    output out_pc
  );

  modport slave (
    input  icache_access,
    input  icache_address,
    output icache_data_ready,
    output icache_data_out,
    input  out_valid,
    output out_ready,
    input  out_instruction,
    input  out_pc
  );

endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencer, one-outstanding icache handshake, queue.
// Define FETCH_BYPASS_EN for same-cycle response-to-decode bypass.
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h1000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  fetch_unit_if.master           bus,
  output logic                   exc_valid,
  output logic [31:0]            exc_pc,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SQUASH,
    ERROR
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } entry_t;

  state_t        state;
  logic [31:0]   rm0;
  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic          q_valid;
  logic          resp;
  logic          byp;
  logic          push;
  logic          pop;
  logic          busy;
  logic          misal;
  logic          room_now;
  logic          room_nxt;
  logic [CW-1:0] cnt_nxt;

  assign q_valid = (count != '0);
  assign resp    = bus.icache_data_ready & (state == REQ);
  assign busy    = (state == REQ) | (state == SQUASH);
  assign misal   = (redirect_pc[1:0] != 2'b00);

`ifdef FETCH_BYPASS_EN
  assign byp = resp & ~q_valid & ~redirect_valid;
`else
  assign byp = 1'b0;
`endif

  // Head of queue, or the live response when bypassing an empty queue.
  always_comb begin
    bus.out_valid       = q_valid | byp;
    bus.out_instruction = '0;
    bus.out_pc          = '0;
    if (q_valid) begin
      bus.out_instruction = mem[rd_ptr].insn;
      bus.out_pc          = mem[rd_ptr].pc;
    end else if (byp) begin
      bus.out_instruction = bus.icache_data_out;
      bus.out_pc          = rm0;
    end
  end

  // Queue bookkeeping; a slot is reserved before every request.
  always_comb begin
    pop      = q_valid & bus.out_ready;
    push     = resp & ~redirect_valid & ~(byp & bus.out_ready);
    cnt_nxt  = count + CW'(push) - CW'(pop);
    room_nxt = (cnt_nxt < CW'(DEPTH));
    room_now = ~((count == CW'(DEPTH)) & ~pop);
  end

  // Fetch sequencer: request issue, completion, squash and error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      rm0                <= RESET_PC;
      bus.icache_access  <= 1'b0;
      bus.icache_address <= RESET_PC;
      exc_valid          <= 1'b0;
      exc_pc             <= '0;
    end else if (redirect_valid) begin
      rm0       <= redirect_pc;
      exc_valid <= misal;
      if (misal) begin
        exc_pc <= redirect_pc;
      end
      if (busy && !bus.icache_data_ready) begin
        state <= SQUASH;
      end else begin
        state             <= misal ? ERROR : IDLE;
        bus.icache_access <= 1'b0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (room_now) begin
            state              <= REQ;
            bus.icache_access  <= 1'b1;
            bus.icache_address <= rm0;
          end
        end
        REQ: begin
          if (bus.icache_data_ready) begin
            rm0 <= rm0 + 32'd4;
            if (room_nxt) begin
              bus.icache_address <= rm0 + 32'd4;
            end else begin
              state             <= IDLE;
              bus.icache_access <= 1'b0;
            end
          end
        end
        SQUASH: begin
          if (bus.icache_data_ready) begin
            state             <= exc_valid ? ERROR : IDLE;
            bus.icache_access <= 1'b0;
          end
        end
        ERROR: begin
        end
      endcase
    end
  end

  // Circular-buffer pointers and occupancy; redirect flushes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= cnt_nxt;
    end
  end

  // Queue storage: {pc, instruction} written on accepted responses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= '{pc: rm0, insn: bus.icache_data_out};
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized traffic against
// an in-order fetch-stream reference model.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h1000;

  logic                   clk            = 1'b0;
  logic                   reset          = 1'b1;
  logic                   redirect_valid = 1'b0;
  logic [31:0]            redirect_pc    = '0;
  logic                   exc_valid;
  logic [31:0]            exc_pc;
  logic [$clog2(DEPTH):0] count;

  fetch_unit_if bus ();

  int          n_cmp     = 0;
  int          n_bad     = 0;
  int          fixed_lat = 1;
  bit          rand_lat  = 1'b0;
  logic [31:0] salt      = '0;

  always #5 clk = ~clk;

  fetch_unit #(
    .DEPTH   (DEPTH),
    .RESET_PC(RPC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .bus           (bus),
    .exc_valid     (exc_valid),
    .exc_pc        (exc_pc),
    .count         (count)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ salt;
  endfunction

  // Instruction cache model: answers each access after a latency.
  initial begin : cache
    bit busy;
    int left;
    busy = 1'b0;
    left = 0;
    bus.icache_data_ready = 1'b0;
    bus.icache_data_out   = '0;
    forever begin
      @(negedge clk);
      bus.icache_data_ready = 1'b0;
      if (!reset || !bus.icache_access) begin
        busy = 1'b0;
      end else begin
        if (!busy) begin
          busy = 1'b1;
          left = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
        end
        if (left == 0) begin
          bus.icache_data_ready = 1'b1;
          bus.icache_data_out   = word(bus.icache_address);
          busy = 1'b0;
        end else begin
          left--;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    bus.out_ready = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (bus.icache_access !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_access got=%0h exp=0", bus.icache_access);
    end
    n_cmp++;
    if (bus.icache_address !== RPC) begin
      n_bad++;
      $display("FAIL rst_address got=%h exp=%h", bus.icache_address, RPC);
    end
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_out_valid got=%0h exp=0", bus.out_valid);
    end
    n_cmp++;
    if (bus.out_instruction !== 32'h0 || bus.out_pc !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_out got=%h/%h exp=0/0",
               bus.out_instruction, bus.out_pc);
    end
    n_cmp++;
    if (exc_valid !== 1'b0 || exc_pc !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_exc got=%0h/%h exp=0/0", exc_valid, exc_pc);
    end
    n_cmp++;
    if (count !== '0) begin
      n_bad++;
      $display("FAIL rst_count got=%0d exp=0", count);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    n_cmp++;
    if (bus.icache_access !== 1'b1 || bus.icache_address !== RPC) begin
      n_bad++;
      $display("FAIL first_req got=%0h@%h exp=1@%h",
               bus.icache_access, bus.icache_address, RPC);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    int got;
    exp = RPC;
    got = 0;
    for (int c = 0; c < 60 && got < 3; c++) begin
      n_cmp++;
      if (int'(count) > 1) begin
        n_bad++;
        $display("FAIL stream_count got=%0d exp<=1", count);
      end
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++;
        if (bus.out_pc !== exp || bus.out_instruction !== exp) begin
          n_bad++;
          $display("FAIL stream_word got=%h/%h exp=%h/%h",
                   bus.out_pc, bus.out_instruction, exp, exp);
        end
        exp += 32'd4;
        got++;
      end
      tick();
    end
    n_cmp++;
    if (got != 3) begin
      n_bad++;
      $display("FAIL stream_timeout got=%0d exp=3", got);
    end
  endtask

  task automatic test_stall();
    int pulses;
    int got;
    bit seen;
    logic [31:0] exp;
    bus.out_ready = 1'b0;
    do_reset();
    pulses = 0;
    repeat (30) begin
      tick();
      if (bus.icache_data_ready) pulses++;
    end
    n_cmp++;
    if (pulses != DEPTH) begin
      n_bad++;
      $display("FAIL stall_resp got=%0d exp=%0d", pulses, DEPTH);
    end
    n_cmp++;
    if (int'(count) != DEPTH) begin
      n_bad++;
      $display("FAIL stall_count got=%0d exp=%0d", count, DEPTH);
    end
    n_cmp++;
    if (bus.icache_access !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_access got=%0h exp=0", bus.icache_access);
    end
    bus.out_ready = 1'b1;
    #1;
    exp  = RPC;
    got  = 0;
    seen = 1'b0;
    for (int c = 0; c < 60 && got < 5; c++) begin
      if (!seen && bus.icache_access) begin
        seen = 1'b1;
        n_cmp++;
        if (bus.icache_address !== 32'h1010) begin
          n_bad++;
          $display("FAIL resume_addr got=%h exp=00001010",
                   bus.icache_address);
        end
      end
      if (bus.out_valid) begin
        n_cmp++;
        if (bus.out_pc !== exp || bus.out_instruction !== exp) begin
          n_bad++;
          $display("FAIL drain_word got=%h/%h exp=%h",
                   bus.out_pc, bus.out_instruction, exp);
        end
        exp += 32'd4;
        got++;
      end
      tick();
    end
    n_cmp++;
    if (got != 5 || !seen) begin
      n_bad++;
      $display("FAIL drain_timeout got=%0d/%0d exp=5/1", got, seen);
    end
  endtask

  task automatic test_redirect();
    bit found;
    bit seen;
    bit got;
    bus.out_ready = 1'b1;
    do_reset();
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      tick();
      if (bus.icache_access && bus.icache_address == 32'h100C &&
          !bus.icache_data_ready) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL redir_setup got=0 exp=1");
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h2000;
    tick();
    redirect_valid = 1'b0;
    #1;
    seen = 1'b0;
    got  = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      if (!seen && bus.icache_access && bus.icache_address != 32'h100C) begin
        seen = 1'b1;
        n_cmp++;
        if (bus.icache_address !== 32'h2000) begin
          n_bad++;
          $display("FAIL redir_addr got=%h exp=00002000",
                   bus.icache_address);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        got = 1'b1;
        n_cmp++;
        if (bus.out_pc !== 32'h2000 || bus.out_instruction !== 32'h2000) begin
          n_bad++;
          $display("FAIL redir_first got=%h/%h exp=00002000",
                   bus.out_pc, bus.out_instruction);
        end
      end
      tick();
    end
    n_cmp++;
    if (!seen || !got) begin
      n_bad++;
      $display("FAIL redir_timeout got=%0d/%0d exp=1/1", seen, got);
    end
  endtask

  task automatic test_misaligned();
    bit seen;
    bit got;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h2002;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_cmp++;
    if (exc_valid !== 1'b1 || exc_pc !== 32'h2002) begin
      n_bad++;
      $display("FAIL exc_set got=%0h/%h exp=1/00002002", exc_valid, exc_pc);
    end
    for (int c = 0; c < 14; c++) begin
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL exc_out got=%0h exp=0", bus.out_valid);
      end
      if (c > 6) begin
        n_cmp++;
        if (bus.icache_access !== 1'b0) begin
          n_bad++;
          $display("FAIL exc_access got=%0h exp=0", bus.icache_access);
        end
      end
      tick();
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h2004;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_cmp++;
    if (exc_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL exc_clear got=%0h exp=0", exc_valid);
    end
    seen = 1'b0;
    got  = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      if (!seen && bus.icache_access) begin
        seen = 1'b1;
        n_cmp++;
        if (bus.icache_address !== 32'h2004) begin
          n_bad++;
          $display("FAIL exc_resume got=%h exp=00002004",
                   bus.icache_address);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        got = 1'b1;
        n_cmp++;
        if (bus.out_pc !== 32'h2004) begin
          n_bad++;
          $display("FAIL exc_first got=%h exp=00002004", bus.out_pc);
        end
      end
      tick();
    end
    n_cmp++;
    if (!seen || !got) begin
      n_bad++;
      $display("FAIL exc_timeout got=%0d/%0d exp=1/1", seen, got);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp;
    int got;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    #1;
    exp = 32'hFFFF_FFFC;
    got = 0;
    for (int c = 0; c < 40 && got < 2; c++) begin
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++;
        if (bus.out_pc !== exp || bus.out_instruction !== exp) begin
          n_bad++;
          $display("FAIL wrap_word got=%h/%h exp=%h",
                   bus.out_pc, bus.out_instruction, exp);
        end
        exp += 32'd4;
        got++;
      end
      tick();
    end
    n_cmp++;
    if (got != 2) begin
      n_bad++;
      $display("FAIL wrap_timeout got=%0d exp=2", got);
    end
  endtask

  task automatic test_bypass();
    bit found;
    bus.out_ready = 1'b1;
    do_reset();
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      found = bus.icache_data_ready;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL byp_setup got=0 exp=1");
    end
`ifdef FETCH_BYPASS_EN
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== RPC) begin
      n_bad++;
      $display("FAIL byp_same got=%0h@%h exp=1@%h",
               bus.out_valid, bus.out_pc, RPC);
    end
    tick();
    n_cmp++;
    if (count !== '0) begin
      n_bad++;
      $display("FAIL byp_count got=%0d exp=0", count);
    end
`else
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL nobyp_same got=%0h exp=0", bus.out_valid);
    end
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== RPC || count !== 1) begin
      n_bad++;
      $display("FAIL nobyp_next got=%0h@%h/%0d exp=1@%h/1",
               bus.out_valid, bus.out_pc, count, RPC);
    end
`endif
  endtask

  task automatic test_random();
    logic [31:0] exp;
    logic [31:0] err_pc;
    logic [31:0] tgt;
    bit err;
    int since;
    int pops;
    rand_lat = 1'b1;
    salt     = 32'h5A5A_0F0F;
    do_reset();
    exp    = RPC;
    err    = 1'b0;
    err_pc = '0;
    since  = 100;
    pops   = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      bus.out_ready  = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 99) < 3);
      tgt = $urandom;
      if ($urandom_range(0, 9) != 0) tgt[1:0] = 2'b00;
      redirect_pc = tgt;
      #1;
      n_cmp++;
      if (exc_valid !== err) begin
        n_bad++;
        $display("FAIL rnd_exc got=%0h exp=%0h", exc_valid, err);
      end
      if (err) begin
        n_cmp++;
        if (exc_pc !== err_pc) begin
          n_bad++;
          $display("FAIL rnd_exc_pc got=%h exp=%h", exc_pc, err_pc);
        end
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL rnd_err_out got=%0h exp=0", bus.out_valid);
        end
        if (since > 6) begin
          n_cmp++;
          if (bus.icache_access !== 1'b0) begin
            n_bad++;
            $display("FAIL rnd_err_access got=%0h exp=0",
                     bus.icache_access);
          end
        end
      end else if (!redirect_valid && bus.out_valid && bus.out_ready) begin
        n_cmp++;
        if (bus.out_pc !== exp || bus.out_instruction !== word(exp)) begin
          n_bad++;
          $display("FAIL rnd_word got=%h/%h exp=%h/%h",
                   bus.out_pc, bus.out_instruction, exp, word(exp));
        end
        exp += 32'd4;
        pops++;
      end
      n_cmp++;
      if (int'(count) > DEPTH) begin
        n_bad++;
        $display("FAIL rnd_count got=%0d exp<=%0d", count, DEPTH);
      end
      if (redirect_valid) begin
        exp   = tgt;
        err   = (tgt[1:0] != 2'b00);
        since = 0;
        if (err) err_pc = tgt;
      end else begin
        since++;
      end
    end
    redirect_valid = 1'b0;
    rand_lat       = 1'b0;
    salt           = '0;
    n_cmp++;
    if (pops < 200) begin
      n_bad++;
      $display("FAIL rnd_progress got=%0d exp>=200", pops);
    end
  endtask

  initial begin
    bus.out_ready = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_misaligned();
    test_wrap();
    test_bypass();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
